convolution_processor_gen2: RTL and testbench
=============================================

# convolution_processor_gen2

Parametrised successor to the fixed-kernel convolution processor: computes the full linear convolution Z = Y * H of a runtime-sized input vector Y, read from an external synchronous RAM, with a runtime-sized kernel H held in an internal loadable register file instead of a file-initialised ROM. It adds configurable widths, signed or unsigned arithmetic, output saturation with a sticky flag, and skips out-of-range products instead of iterating over them. It sits between the Y RAM and the Z RAM, under the same start/busy/done control as the previous generation.

## Interface
- DATA_Y_WIDTH, 8, Y sample width
- DATA_H_WIDTH, 8, kernel coefficient width
- DATA_Z_WIDTH, 16, output sample width
- SIZE_Y_WIDTH, 5, width of sizeY_i; also the Y address width
- H_DEPTH, 16, kernel register file depth; HA = $clog2(H_DEPTH)
- MEMZ_ADDR_WIDTH, 6, Z address width; must hold 2^SIZE_Y_WIDTH + H_DEPTH - 2
- SIGNED, 0, 1 = two's-complement Y, H, Z; 0 = unsigned
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- start_i  in  1  start request, sampled in IDLE only
- sizeY_i  in  SIZE_Y_WIDTH  Y length, latched at start
- sizeH_i  in  HA+1  kernel length, latched at start
- hload_i  in  1  kernel write strobe
- hload_addr_i  in  HA  kernel write index
- hload_data_i  in  DATA_H_WIDTH  kernel write data
- dataY_i  in  DATA_Y_WIDTH  Y RAM read data, valid one cycle after address
- memY_addr_o  out  SIZE_Y_WIDTH  Y RAM read address
- dataZ_o  out  DATA_Z_WIDTH  Z sample, saturated
- memZ_addr_o  out  MEMZ_ADDR_WIDTH  Z write address
- writeZ_o  out  1  Z write strobe, one cycle per sample
- busy_o  out  1  high from INIT through the last WRITE
- done_o  out  1  one-cycle completion pulse
- sat_o  out  1  sticky: some output of the current run saturated

## Operation
- Reset values: all outputs 0, kernel registers 0, state IDLE.
- Kernel load: hload_i in any non-busy cycle writes H[hload_addr_i]; ignored while busy_o = 1.
- IDLE: start_i = 1 -> INIT. start_i while busy is ignored.
- INIT: latch sizeY, sizeH; sizeZ = sizeY + sizeH - 1; n = 0; clear sat_o. If sizeY = 0, sizeH = 0 or sizeH > H_DEPTH -> DONE with no Z writes.
- SETUP: k_lo = max(0, n - sizeH + 1), k_hi = min(n, sizeY - 1); k = k_lo; clear accumulator -> MAC.
- MAC: memY_addr_o = k; the product dataY_i * H[n - k_prev] is added one cycle later (pipelined). k increments each cycle; after k_hi is issued -> FLUSH.
- FLUSH: accumulate the last product -> WRITE.
- WRITE: dataZ_o = sat(acc), memZ_addr_o = n, writeZ_o = 1; set sat_o if clipped; n++; if n = sizeZ -> DONE, else -> SETUP.
- DONE: done_o = 1, busy_o = 0 -> IDLE.
- Arithmetic: accumulator width DATA_Y_WIDTH + DATA_H_WIDTH + SIZE_Y_WIDTH, exact (no overflow). Product and sum signedness follow SIGNED. Saturation clamps to [0, 2^DATA_Z_WIDTH - 1] unsigned, or [-2^(DATA_Z_WIDTH-1), 2^(DATA_Z_WIDTH-1) - 1] signed.
- dataZ_o, memZ_addr_o and sat_o hold between writes; memY_addr_o holds its last value outside MAC.
- rstn low at any time aborts the run immediately. No partial done; the kernel is cleared.

## Timing
- Outputs are registered. writeZ_o, dataZ_o and memZ_addr_o change together.
- Per output n: 1 SETUP + T_n MAC + 1 FLUSH + 1 WRITE, where T_n = k_hi - k_lo + 1.
- Total, from the start-sampling edge to the done_o pulse: 1 + sizeY*sizeH + 3*sizeZ + 1 cycles. The empty case takes 2 cycles.
- done_o is asserted the cycle after the last writeZ_o.

## Structure
- Package convolution_processor_gen2_pkg: state enum (IDLE, INIT, SETUP, MAC, FLUSH, WRITE, DONE), the accumulator-width constant function, and the saturation function.
- Sub-module convolution_processor_gen2_mac: pipelined multiply-accumulate with clear, enable and saturating output, parametrised by widths and SIGNED.
- Top level: FSM, counters n and k, kernel register file.

## Test plan
- Unsigned, H = [1,2,3], Y = [1,1] -> Z writes [1,3,5,3] at addresses 0..3; done_o at cycle 20; sat_o = 0.
- Unsigned, sizeY = sizeH = 2, all samples 255 -> Z = [65025, 65535(sat), 65025]; sat_o = 1 after the address-1 write.
- SIGNED = 1, Y = [-128,-128], H = [-128,-128] -> Z = [16384, 32767(sat), 16384]; with Y = [-1,2], H = [3] -> Z = [-3, 6].
- sizeH_i = 0 or sizeH_i = H_DEPTH + 1 -> no writeZ_o; done_o 2 cycles after start.
- hload_i during busy changes H[0] -> ignored, the result equals the pre-start kernel; start_i pulsed mid-run -> ignored.
- rstn asserted in MAC -> all outputs 0 at once, kernel reads back 0; a new start runs cleanly.

Source files
------------

// File: rtl/convolution_processor_gen2_pkg.sv
// -----------------------------------------------------------------------------
// convolution_processor_gen2_pkg
// Shared definitions for the runtime-sized convolution processor:
//   - state_t        : controller states
//   - acc_width()    : exact accumulator width for a given set of data widths
//   - sat_clamp()    : clamp a wide two's-complement value into the output range
// -----------------------------------------------------------------------------
package convolution_processor_gen2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SETUP,
        MAC,
        FLUSH,
        WRITE,
        DONE
    } state_t;

    // One product needs DY+DH bits; summing up to 2^SY of them needs SY more.
    function automatic int acc_width(input int dy, input int dh, input int sy);
        return dy + dh + sy;
    endfunction

    // Clamp v into [0, 2^zw-1] (unsigned) or [-2^(zw-1), 2^(zw-1)-1] (signed).
    // The caller compares the result with v to detect clipping.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int zw,
                                                     input bit sgn);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (sgn) begin
            hi = (64'sd1 <<< (zw - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (zw - 1));
        end else begin
            hi = (64'sd1 <<< zw) - 64'sd1;
            lo = 64'sd0;
        end
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/convolution_processor_gen2_mac.sv
// -----------------------------------------------------------------------------
// convolution_processor_gen2_mac
// Multiply-accumulate stage. The accumulator is exact (never overflows).
// o_z / o_clip are the saturated view of the value the accumulator will hold
// after this cycle's update, so the controller can register the finished
// sample on the same edge that absorbs the last product.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clear       : zero the accumulator (has priority over i_en)
//   i_en          : add i_y * i_h this cycle
//   i_y, i_h      : operands (signedness set by SIGNED)
//   o_z           : saturated next accumulator value
//   o_clip        : o_z differs from the exact next accumulator value
// -----------------------------------------------------------------------------
module convolution_processor_gen2_mac
    import convolution_processor_gen2_pkg::*;
#(
    parameter int DY     = 8,
    parameter int DH     = 8,
    parameter int ZW     = 16,
    parameter int SY     = 5,
    parameter int SIGNED = 0
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic [DY-1:0] i_y,
    input  logic [DH-1:0] i_h,
    output logic [ZW-1:0] o_z,
    output logic          o_clip
);

    localparam int AW = acc_width(DY, DH, SY);

    logic                 w_sgn;
    logic signed [AW-1:0] w_y_ext;
    logic signed [AW-1:0] w_h_ext;
    logic signed [AW-1:0] w_prod;
    logic signed [AW-1:0] w_acc_next;
    logic signed [63:0]   w_wide;
    logic signed [63:0]   w_clamped;
    logic signed [AW-1:0] r_acc;

    assign w_sgn = (SIGNED != 0);

    always_comb begin
        // Extend both operands to the accumulator width so the product and
        // the sum are computed exactly in a single signed domain.
        w_y_ext    = {{(AW-DY){w_sgn & i_y[DY-1]}}, i_y};
        w_h_ext    = {{(AW-DH){w_sgn & i_h[DH-1]}}, i_h};
        w_prod     = w_y_ext * w_h_ext;
        w_acc_next = i_en ? (r_acc + w_prod) : r_acc;
        w_wide     = {{(64-AW){w_sgn & w_acc_next[AW-1]}}, w_acc_next};
        w_clamped  = sat_clamp(w_wide, ZW, w_sgn);
        o_z        = w_clamped[ZW-1:0];
        o_clip     = (w_clamped != w_wide);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: rtl/convolution_processor_gen2.sv
// -----------------------------------------------------------------------------
// convolution_processor_gen2
// Full linear convolution Z = Y * H. Y is read from an external synchronous
// RAM (one cycle read latency), H lives in an internal loadable register file,
// Z samples are written out saturated, one per output index n.
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   start_i                    : start request (honoured in IDLE only)
//   sizeY_i, sizeH_i           : Y and H lengths, captured with start
//   hload_i/_addr_i/_data_i    : kernel write port, ignored while busy
//   dataY_i / memY_addr_o      : Y RAM read port
//   dataZ_o, memZ_addr_o,
//   writeZ_o                   : Z RAM write port
//   busy_o, done_o             : run status, done is a one-cycle pulse
//   sat_o                      : sticky, some sample of this run clipped
// -----------------------------------------------------------------------------
module convolution_processor_gen2
    import convolution_processor_gen2_pkg::*;
#(
    parameter int DATA_Y_WIDTH    = 8,
    parameter int DATA_H_WIDTH    = 8,
    parameter int DATA_Z_WIDTH    = 16,
    parameter int SIZE_Y_WIDTH    = 5,
    parameter int H_DEPTH         = 16,
    parameter int MEMZ_ADDR_WIDTH = 6,
    parameter int SIGNED          = 0,
    localparam int HA             = $clog2(H_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic [SIZE_Y_WIDTH-1:0]    sizeY_i,
    input  logic [HA:0]                sizeH_i,
    input  logic                       hload_i,
    input  logic [HA-1:0]              hload_addr_i,
    input  logic [DATA_H_WIDTH-1:0]    hload_data_i,
    input  logic [DATA_Y_WIDTH-1:0]    dataY_i,
    output logic [SIZE_Y_WIDTH-1:0]    memY_addr_o,
    output logic [DATA_Z_WIDTH-1:0]    dataZ_o,
    output logic [MEMZ_ADDR_WIDTH-1:0] memZ_addr_o,
    output logic                       writeZ_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       sat_o
);

    // Index arithmetic runs one bit wider than the Z address so n+1 and
    // sizeY+sizeH-1 never wrap.
    localparam int NW = MEMZ_ADDR_WIDTH + 1;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [SIZE_Y_WIDTH-1:0]     r_size_y;
    logic [HA:0]                 r_size_h;
    logic [MEMZ_ADDR_WIDTH-1:0]  r_n;
    logic [SIZE_Y_WIDTH-1:0]     r_k;
    logic [SIZE_Y_WIDTH-1:0]     r_k_hi;
    logic [HA-1:0]               r_h_idx;
    logic                        r_prod_valid;
    logic [DATA_H_WIDTH-1:0]     r_h [H_DEPTH];

    logic [NW-1:0]               w_n;
    logic [NW-1:0]               w_size_y;
    logic [NW-1:0]               w_size_h;
    logic [NW-1:0]               w_size_z;
    logic [NW-1:0]               w_k_lo;
    logic [NW-1:0]               w_k_hi;
    logic                        w_empty;
    logic                        w_k_last;
    logic                        w_n_last;
    logic [DATA_Z_WIDTH-1:0]     w_z_sat;
    logic                        w_clip;

    assign memY_addr_o = r_k;

    always_comb begin
        w_n      = NW'(r_n);
        w_size_y = NW'(r_size_y);
        w_size_h = NW'(r_size_h);
        w_size_z = w_size_y + w_size_h - NW'(1);
        w_empty  = (r_size_y == '0) || (r_size_h == '0) || (w_size_h > NW'(H_DEPTH));
        // Only k with 0 <= n-k < sizeH and 0 <= k < sizeY contribute.
        w_k_lo   = (w_n + NW'(1) > w_size_h) ? (w_n + NW'(1) - w_size_h) : '0;
        w_k_hi   = (w_n < w_size_y - NW'(1)) ? w_n : (w_size_y - NW'(1));
        w_k_last = (r_k == r_k_hi);
        w_n_last = (w_n + NW'(1) == w_size_z);
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_next = INIT;
            INIT:    w_state_next = w_empty ? DONE : SETUP;
            SETUP:   w_state_next = MAC;
            MAC:     if (w_k_last) w_state_next = FLUSH;
            FLUSH:   w_state_next = WRITE;
            WRITE:   w_state_next = w_n_last ? DONE : SETUP;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- datapath and registered outputs ----------------
    // Status outputs are registered from the next state so they are high
    // exactly during the WRITE / DONE / busy cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_size_y     <= '0;
            r_size_h     <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_k_hi       <= '0;
            r_h_idx      <= '0;
            r_prod_valid <= 1'b0;
            dataZ_o      <= '0;
            memZ_addr_o  <= '0;
            writeZ_o     <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            sat_o        <= 1'b0;
        end else begin
            // The Y RAM returns data one cycle after the address, so the
            // matching kernel index is delayed by one cycle as well.
            r_prod_valid <= (r_state == MAC);
            r_h_idx      <= HA'(w_n - NW'(r_k));
            writeZ_o     <= (w_state_next == WRITE);
            done_o       <= (w_state_next == DONE);
            busy_o       <= (w_state_next != IDLE) && (w_state_next != DONE);
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_size_y <= sizeY_i;
                        r_size_h <= sizeH_i;
                    end
                end
                INIT: begin
                    r_n   <= '0;
                    sat_o <= 1'b0;
                end
                SETUP: begin
                    r_k    <= SIZE_Y_WIDTH'(w_k_lo);
                    r_k_hi <= SIZE_Y_WIDTH'(w_k_hi);
                end
                MAC: begin
                    if (!w_k_last) r_k <= r_k + SIZE_Y_WIDTH'(1);
                end
                FLUSH: begin
                    // The MAC output already includes the product arriving now.
                    dataZ_o     <= w_z_sat;
                    memZ_addr_o <= r_n;
                    sat_o       <= sat_o | w_clip;
                end
                WRITE: begin
                    r_n <= r_n + MEMZ_ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- kernel register file ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < H_DEPTH; i++) r_h[i] <= '0;
        end else if (hload_i && !busy_o && (int'(hload_addr_i) < H_DEPTH)) begin
            r_h[hload_addr_i] <= hload_data_i;
        end
    end

    convolution_processor_gen2_mac #(
        .DY     (DATA_Y_WIDTH),
        .DH     (DATA_H_WIDTH),
        .ZW     (DATA_Z_WIDTH),
        .SY     (SIZE_Y_WIDTH),
        .SIGNED (SIGNED)
    ) u_mac (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_clear (r_state == SETUP),
        .i_en    (r_prod_valid),
        .i_y     (dataY_i),
        .i_h     (r_h[r_h_idx]),
        .o_z     (w_z_sat),
        .o_clip  (w_clip)
    );

endmodule

// File: tb/tb_convolution_processor_gen2.sv
// -----------------------------------------------------------------------------
// Bench for convolution_processor_gen2. Two instances (unsigned and signed)
// share all control inputs and the same Y RAM contents; a reference model
// computes Z by the convolution sum and queues the expected writes for each.
// Expected write word: {sticky_sat, 9'b0, addr[5:0], data[15:0]}.
// -----------------------------------------------------------------------------
module tb_convolution_processor_gen2;

    localparam int H_DEPTH = 16;
    localparam int BUDGET  = 2000;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [4:0]  size_y;
    logic [4:0]  size_h;
    logic        hload;
    logic [3:0]  hload_addr;
    logic [7:0]  hload_data;

    logic [7:0]  y_u, y_s;
    logic [4:0]  ya_u, ya_s;
    logic [15:0] z_u, z_s;
    logic [5:0]  za_u, za_s;
    logic        wz_u, wz_s, busy_u, busy_s, done_u, done_s, sat_u, sat_s;

    logic [7:0]  mem_y [32];
    logic [7:0]  h_model [H_DEPTH];
    logic [31:0] exp_u_q [$];
    logic [31:0] exp_s_q [$];

    int n_checks;
    int n_fail;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    convolution_processor_gen2 #(.SIGNED(0)) u_dut_u (
        .clk(clk), .rstn(rstn), .start_i(start), .sizeY_i(size_y), .sizeH_i(size_h),
        .hload_i(hload), .hload_addr_i(hload_addr), .hload_data_i(hload_data),
        .dataY_i(y_u), .memY_addr_o(ya_u), .dataZ_o(z_u), .memZ_addr_o(za_u),
        .writeZ_o(wz_u), .busy_o(busy_u), .done_o(done_u), .sat_o(sat_u)
    );

    convolution_processor_gen2 #(.SIGNED(1)) u_dut_s (
        .clk(clk), .rstn(rstn), .start_i(start), .sizeY_i(size_y), .sizeH_i(size_h),
        .hload_i(hload), .hload_addr_i(hload_addr), .hload_data_i(hload_data),
        .dataY_i(y_s), .memY_addr_o(ya_s), .dataZ_o(z_s), .memZ_addr_o(za_s),
        .writeZ_o(wz_s), .busy_o(busy_s), .done_o(done_s), .sat_o(sat_s)
    );

    // Synchronous Y RAM: data one cycle after the address.
    always @(posedge clk) begin
        y_u <= mem_y[ya_u];
        y_s <= mem_y[ya_s];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic build_expected(input int sy, input int sh);
        int su, ss, cu, cs;
        bit stu, sts;
        exp_u_q.delete();
        exp_s_q.delete();
        stu = 1'b0;
        sts = 1'b0;
        if (sy == 0 || sh == 0 || sh > H_DEPTH) return;
        for (int n = 0; n < sy + sh - 1; n++) begin
            su = 0;
            ss = 0;
            for (int k = 0; k < sy; k++) begin
                if (n - k >= 0 && n - k < sh) begin
                    su += int'(mem_y[k]) * int'(h_model[n-k]);
                    ss += int'($signed(mem_y[k])) * int'($signed(h_model[n-k]));
                end
            end
            cu = (su > 65535) ? 65535 : su;
            if (cu != su) stu = 1'b1;
            cs = (ss > 32767) ? 32767 : ((ss < -32768) ? -32768 : ss);
            if (cs != ss) sts = 1'b1;
            exp_u_q.push_back({stu, 9'b0, 6'(n), 16'(cu)});
            exp_s_q.push_back({sts, 9'b0, 6'(n), 16'(cs)});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load_h(input int addr, input logic [7:0] data);
        @(negedge clk);
        hload      = 1'b1;
        hload_addr = 4'(addr);
        hload_data = data;
        h_model[addr] = data;
        @(negedge clk);
        hload = 1'b0;
    endtask

    task automatic load_h_random();
        for (int i = 0; i < H_DEPTH; i++) load_h(i, 8'($urandom_range(0, 255)));
    endtask

    // Runs one convolution and checks every Z write, sat_o, and the latency.
    // Latency is counted in rising edges from the start-sampling edge (1) to
    // the edge after which done_o is seen high.
    task automatic run_conv(input int sy, input int sh, input bit hl_busy, input bit start_mid);
        int cyc, exp_cyc, done_u_cyc, done_s_cyc, last_u, last_s;
        bit empty;
        build_expected(sy, sh);
        empty   = (sy == 0 || sh == 0 || sh > H_DEPTH);
        exp_cyc = empty ? 2 : 2 + sy * sh + 3 * (sy + sh - 1);
        done_u_cyc = -1;
        done_s_cyc = -1;
        last_u = -1;
        last_s = -1;
        @(negedge clk);
        size_y = 5'(sy);
        size_h = 5'(sh);
        start  = 1'b1;
        @(posedge clk);
        cyc = 1;
        while ((done_u_cyc < 0 || done_s_cyc < 0) && cyc < BUDGET) begin
            @(negedge clk);
            start = 1'b0;
            hload = 1'b0;
            if (hl_busy && cyc == 3) begin
                hload      = 1'b1;
                hload_addr = 4'd0;
                hload_data = ~h_model[0];
            end
            if (start_mid && cyc == 4) start = 1'b1;
            if (cyc == 2) begin
                check("sat_clr_u", 32'(sat_u), 32'd0);
                check("sat_clr_s", 32'(sat_s), 32'd0);
            end
            if (wz_u) begin
                last_u = cyc;
                if (exp_u_q.size() == 0) check("extra_wr_u", 32'd1, 32'd0);
                else check("z_u", {sat_u, 9'b0, za_u, z_u}, exp_u_q.pop_front());
            end
            if (wz_s) begin
                last_s = cyc;
                if (exp_s_q.size() == 0) check("extra_wr_s", 32'd1, 32'd0);
                else check("z_s", {sat_s, 9'b0, za_s, z_s}, exp_s_q.pop_front());
            end
            if (done_u && done_u_cyc < 0) done_u_cyc = cyc;
            if (done_s && done_s_cyc < 0) done_s_cyc = cyc;
            if (done_u_cyc < 0 || done_s_cyc < 0) begin
                @(posedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        hload = 1'b0;
        check("latency_u", 32'(done_u_cyc), 32'(exp_cyc));
        check("latency_s", 32'(done_s_cyc), 32'(exp_cyc));
        check("missing_wr_u", 32'(exp_u_q.size()), 32'd0);
        check("missing_wr_s", 32'(exp_s_q.size()), 32'd0);
        if (!empty) begin
            check("done_after_wr_u", 32'(done_u_cyc), 32'(last_u + 1));
            check("done_after_wr_s", 32'(done_s_cyc), 32'(last_s + 1));
        end else begin
            check("no_wr_u", 32'(last_u), 32'hffff_ffff);
            check("no_wr_s", 32'(last_s), 32'hffff_ffff);
        end
    endtask

    task automatic check_outputs_zero(input string tag_u, input string tag_s);
        check(tag_u, {3'b0, busy_u, done_u, wz_u, sat_u, z_u, za_u, ya_u}, 32'd0);
        check(tag_s, {3'b0, busy_s, done_s, wz_s, sat_s, z_s, za_s, ya_s}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rstn       = 1'b0;
        start      = 1'b0;
        size_y     = '0;
        size_h     = '0;
        hload      = 1'b0;
        hload_addr = '0;
        hload_data = '0;
        for (int i = 0; i < 32; i++) mem_y[i] = '0;
        for (int i = 0; i < H_DEPTH; i++) h_model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_u", "reset_s");
        @(negedge clk);
        rstn = 1'b1;

        // H = [1,2,3], Y = [1,1] -> [1,3,5,3], 20 cycles
        load_h(0, 8'd1); load_h(1, 8'd2); load_h(2, 8'd3);
        mem_y[0] = 8'd1; mem_y[1] = 8'd1;
        run_conv(2, 3, 1'b0, 1'b0);

        // All 255: unsigned clips the middle sample
        load_h(0, 8'd255); load_h(1, 8'd255);
        mem_y[0] = 8'd255; mem_y[1] = 8'd255;
        run_conv(2, 2, 1'b0, 1'b0);

        // All 0x80: signed clips the middle sample
        load_h(0, 8'h80); load_h(1, 8'h80);
        mem_y[0] = 8'h80; mem_y[1] = 8'h80;
        run_conv(2, 2, 1'b0, 1'b0);

        // Y = [-1, 2], H = [3]
        load_h(0, 8'd3);
        mem_y[0] = 8'hff; mem_y[1] = 8'd2;
        run_conv(2, 1, 1'b0, 1'b0);

        // Empty runs
        run_conv(2, 0, 1'b0, 1'b0);
        run_conv(2, H_DEPTH + 1, 1'b0, 1'b0);
        run_conv(0, 3, 1'b0, 1'b0);

        // Largest kernel, kernel write and start pulse during the run
        load_h_random();
        for (int i = 0; i < 32; i++) mem_y[i] = 8'($urandom_range(0, 255));
        run_conv(3, H_DEPTH, 1'b1, 1'b1);

        // Randomized runs
        for (int t = 0; t < 12; t++) begin
            load_h_random();
            for (int i = 0; i < 32; i++) mem_y[i] = 8'($urandom_range(0, 255));
            run_conv($urandom_range(0, 31), $urandom_range(0, H_DEPTH + 1),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run
        load_h_random();
        for (int i = 0; i < 32; i++) mem_y[i] = 8'($urandom_range(1, 255));
        @(negedge clk);
        size_y = 5'd20;
        size_h = 5'd10;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_outputs_zero("abort_u", "abort_s");
        for (int i = 0; i < H_DEPTH; i++) h_model[i] = '0;
        @(negedge clk);
        rstn = 1'b1;
        // Cleared kernel must give all-zero outputs
        run_conv(5, 3, 1'b0, 1'b0);
        // And a normal run afterwards
        load_h_random();
        run_conv(7, 4, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
